// File: rtl/ram_bist.sv
// BIST initiator for a 2^AW x DW single-port synchronous RAM: two write/read-compare passes.
// Optional macro RAM_BIST_ERRLOG_EN adds first-failure address/data capture.
module ram_bist #(
    parameter int              AW      = 5,
    parameter int              DW      = 32,
    parameter logic [DW-1:0]   PATTERN = DW'(32'hA5A5_5A5A)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [5:0]    err_cnt,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_data,
    output logic          cen,
    output logic          wen,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] din,
    input  logic [DW-1:0] dout
);

    typedef enum logic [2:0] {IDLE, WR, RD, FLUSH, FIN} state_e;

    localparam logic [AW-1:0] A_LAST  = '1;
    localparam logic [5:0]    ERR_MAX = 6'h3f;

    state_e          state_q, state_d;
    logic [AW-1:0]   a_q, a_d;
    logic            p_q, p_d;
    logic            rd_vld_q, rd_vld_d;
    logic [AW-1:0]   cmp_addr_q, cmp_addr_d;
    logic            cmp_p_q, cmp_p_d;
    logic [5:0]      err_cnt_q, err_cnt_d;
    logic            pass_q, pass_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            cen_q, cen_d;
    logic            wen_q, wen_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   din_q, din_d;
    logic            clear;
    logic            mismatch;

    function automatic logic [DW-1:0] wdata(input logic p, input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = PATTERN ^ {{(DW-AW){1'b0}}, a};
        return p ? ~v : v;
    endfunction

    // Sequencer: walks WR -> RD -> FLUSH twice, second pass with inverted data.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        p_d        = p_q;
        rd_vld_d   = 1'b0;
        cmp_addr_d = cmp_addr_q;
        cmp_p_d    = cmp_p_q;
        clear      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    p_d     = 1'b0;
                    a_d     = '0;
                    state_d = WR;
                end
            end
            WR: begin
                a_d = a_q + AW'(1);
                if (a_q == A_LAST) begin
                    a_d     = '0;
                    state_d = RD;
                end
            end
            RD: begin
                rd_vld_d   = 1'b1;
                cmp_addr_d = a_q;
                cmp_p_d    = p_q;
                a_d        = a_q + AW'(1);
                if (a_q == A_LAST) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (!p_q) begin
                    p_d     = 1'b1;
                    a_d     = '0;
                    state_d = WR;
                end else begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Compare stage: dout answers the read issued one cycle earlier.
    always_comb begin
        mismatch  = rd_vld_q && (dout != wdata(cmp_p_q, cmp_addr_q));
        err_cnt_d = err_cnt_q;
        if (clear) begin
            err_cnt_d = '0;
        end else if (mismatch && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + 6'd1;
        end

        pass_d = pass_q;
        if (clear) begin
            pass_d = 1'b0;
        end else if (state_d == FIN) begin
            pass_d = (err_cnt_d == '0);
        end
    end

    // RAM-side and status outputs are registered from the next state.
    always_comb begin
        busy_d = (state_d == WR) || (state_d == RD) || (state_d == FLUSH);
        done_d = (state_d == FIN);
        cen_d  = (state_d == WR) || (state_d == RD);
        wen_d  = (state_d == WR);
        addr_d = cen_d ? a_d : '0;
        din_d  = wen_d ? wdata(p_d, a_d) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            p_q       <= 1'b0;
            rd_vld_q  <= 1'b0;
            err_cnt_q <= '0;
            pass_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cen_q     <= 1'b0;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            p_q       <= p_d;
            rd_vld_q  <= rd_vld_d;
            err_cnt_q <= err_cnt_d;
            pass_q    <= pass_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cen_q     <= cen_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
        end
    end

    // Compare tags are only consumed when rd_vld_q is set, so they need no reset.
    always_ff @(posedge clk) begin
        cmp_addr_q <= cmp_addr_d;
        cmp_p_q    <= cmp_p_d;
    end

`ifdef RAM_BIST_ERRLOG_EN
    logic [AW-1:0] fail_addr_q;
    logic [DW-1:0] fail_data_q;

    // err_cnt never returns to zero within a test, so a zero count marks the first miss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else if (clear) begin
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else if (mismatch && (err_cnt_q == '0)) begin
            fail_addr_q <= cmp_addr_q;
            fail_data_q <= dout;
        end
    end

    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
`else
    assign fail_addr = '0;
    assign fail_data = '0;
`endif

    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_cnt = err_cnt_q;
    assign cen     = cen_q;
    assign wen     = wen_q;
    assign addr    = addr_q;
    assign din     = din_q;

endmodule

// File: tb/tb_ram_bist.sv
// Scoreboard bench for ram_bist with a behavioural 32x32 RAM and injectable read faults.
// Expected results are queued at each accepted start and checked at the done pulse.
module tb_ram_bist;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy, done, pass;
    logic [5:0]  err_cnt;
    logic [4:0]  fail_addr;
    logic [31:0] fail_data;
    logic        cen, wen;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;

    ram_bist #(.AW(5), .DW(32), .PATTERN(32'hA5A5_5A5A)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .fail_addr(fail_addr), .fail_data(fail_data),
        .cen(cen), .wen(wen), .addr(addr), .din(din), .dout(dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0 good, 1 bit0 stuck-at-1 at addr 4, 2 dout stuck at 0, 3 dout delayed one extra cycle
    int          mode;
    logic [31:0] mem [32];
    logic [31:0] rd, rd_d;

    always @(posedge clk) begin
        if (cen) begin
            if (wen) mem[addr] <= din;
            else     rd <= mem[addr] | ((mode == 1 && addr == 5'd4) ? 32'd1 : 32'd0);
        end
        rd_d <= rd;
    end
    assign dout = (mode == 2) ? 32'd0 : (mode == 3) ? rd_d : rd;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        pass;
        logic [5:0]  err;
        logic [4:0]  faddr;
        logic [31:0] fdata;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   t0 = 0;
    int   done_cnt = 0;
    bit   run_active = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wexp(input bit p, input int a);
        logic [31:0] v;
        v = 32'hA5A5_5A5A ^ 32'(a);
        return p ? ~v : v;
    endfunction

    function automatic exp_t calc_exp(input int m);
        exp_t        e;
        logic [31:0] obs;
        e.err   = '0;
        e.faddr = '0;
        e.fdata = '0;
        if (m == 3) begin
            // every compare sees the previous read; the first sees the last read of the prior good run
            e.err   = 6'd63;
            e.faddr = 5'd0;
            e.fdata = wexp(1'b1, 31);
        end else begin
            for (int p = 0; p < 2; p++) begin
                for (int a = 0; a < 32; a++) begin
                    obs = wexp(p[0], a);
                    if (m == 1 && a == 4) obs = obs | 32'd1;
                    if (m == 2) obs = 32'd0;
                    if (obs != wexp(p[0], a)) begin
                        if (e.err == 0) begin
                            e.faddr = 5'(a);
                            e.fdata = obs;
                        end
                        if (e.err != 6'd63) e.err = e.err + 6'd1;
                    end
                end
            end
        end
        e.pass = (e.err == 0);
`ifndef RAM_BIST_ERRLOG_EN
        e.faddr = '0;
        e.fdata = '0;
`endif
        return e;
    endfunction

    // Monitor on the falling edge, away from the active edge.
    initial begin
        int   rel;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                rel = cyc - t0;
                if (!cen) begin
                    check("idle_addr", 64'(addr), 64'(0));
                    check("idle_din", 64'(din), 64'(0));
                end
                if (run_active && rel == 1) begin
                    check("c1_cen", 64'(cen), 64'(1));
                    check("c1_wen", 64'(wen), 64'(1));
                    check("c1_addr", 64'(addr), 64'(0));
                    check("c1_din", 64'(din), 64'(32'hA5A5_5A5A));
                    check("c1_busy", 64'(busy), 64'(1));
                    check("c1_err_clr", 64'(err_cnt), 64'(0));
                    check("c1_pass_clr", 64'(pass), 64'(0));
                    check("c1_faddr_clr", 64'(fail_addr), 64'(0));
                end
                if (run_active && rel == 66) begin
                    check("c66_wen", 64'(wen), 64'(1));
                    check("c66_din", 64'(din), 64'(32'h5A5A_A5A5));
                end
                if (run_active && rel == 130) begin
                    check("c130_busy", 64'(busy), 64'(1));
                    check("c130_cen", 64'(cen), 64'(0));
                end
                if (done) begin
                    if (sb_q.size() == 0) begin
                        check("spurious_done", 64'(1), 64'(0));
                    end else begin
                        e = sb_q.pop_front();
                        check("done_cycle", 64'(rel), 64'(131));
                        check("done_busy", 64'(busy), 64'(0));
                        check("pass", 64'(pass), 64'(e.pass));
                        check("err_cnt", 64'(err_cnt), 64'(e.err));
                        check("fail_addr", 64'(fail_addr), 64'(e.faddr));
                        check("fail_data", 64'(fail_data), 64'(e.fdata));
                    end
                    run_active = 0;
                    done_cnt++;
                end
            end
        end
    end

    task automatic do_run(input int m, input int restart_at, input int rst_at);
        int base;
        bit hit;
        mode = m;
        base = done_cnt;
        sb_q.push_back(calc_exp(m));
        t0 = cyc;
        run_active = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hit = 0;
        for (int i = 0; i < 300; i++) begin
            start = ((cyc - t0) == restart_at);
            if ((cyc - t0) == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_cen", 64'(cen), 64'(0));
                check("rst_busy", 64'(busy), 64'(0));
                check("rst_done", 64'(done), 64'(0));
                check("rst_err", 64'(err_cnt), 64'(0));
                sb_q.delete();
                run_active = 0;
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                hit = 1;
                break;
            end
            @(posedge clk); #1;
            if (done_cnt != base) begin
                hit = 1;
                break;
            end
        end
        start = 1'b0;
        if (!hit) check("done_timeout", 64'(0), 64'(1));
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy0", 64'(busy), 64'(0));
        check("rst_done0", 64'(done), 64'(0));
        check("rst_pass0", 64'(pass), 64'(0));
        check("rst_err0", 64'(err_cnt), 64'(0));
        check("rst_faddr0", 64'(fail_addr), 64'(0));
        check("rst_fdata0", 64'(fail_data), 64'(0));
        check("rst_cen0", 64'(cen), 64'(0));
        check("rst_wen0", 64'(wen), 64'(0));
        check("rst_addr0", 64'(addr), 64'(0));
        check("rst_din0", 64'(din), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        do_run(0, -1, -1);   // good RAM
        do_run(1, -1, -1);   // bit 0 stuck-at-1 at addr 4
        do_run(0, 50, -1);   // rerun clears results; extra start mid-test ignored
        do_run(2, -1, -1);   // dout stuck at zero, count saturates
        do_run(0, -1, 40);   // reset mid-test, no done expected
        base = done_cnt;
        repeat (150) @(posedge clk);
        #1;
        check("no_done_after_rst", 64'(done_cnt), 64'(base));
        do_run(0, -1, -1);   // fresh start after reset
        do_run(3, -1, -1);   // extra read latency

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
